// File: rtl/data_wbuf.sv
// Posted-write buffer between a core data port and memory; writes drain in FIFO order.
// Optional build macro WBUF_READ_BYPASS_EN lets reads overtake buffered writes to other words.
module data_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_cache,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_cache,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        wbuf_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] { IDLE, WR_ADDR, WR_WAIT, RD_ADDR, RD_WAIT } state_e;

    state_e        state_q;
    logic          memReq_q;
    logic [AW:0]   rdPtr_q, rdPtr_d;
    logic [AW:0]   wrPtr_q, wrPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          wrAck_q;
    logic          rdOut_q;
    logic [31:0]   rdAddr_q;
    logic [2:0]    rdSize_q;
    logic          rdCache_q;

    logic [31:0]   entAddr_q  [DEPTH];
    logic [31:0]   entData_q  [DEPTH];
    logic [3:0]    entStrb_q  [DEPTH];
    logic [2:0]    entSize_q  [DEPTH];
    logic          entCache_q [DEPTH];

    logic          push, pop, rdAccept, rdAllowed, orderOk, busyWrite, rdSel;
    logic [AW-1:0] headIdx, tailIdx;

    assign headIdx   = rdPtr_q[AW-1:0];
    assign tailIdx   = wrPtr_q[AW-1:0];
    assign busyWrite = (state_q == WR_ADDR) || (state_q == WR_WAIT);
    assign wbuf_empty = reset || ((count_q == '0) && !busyWrite);

`ifdef WBUF_READ_BYPASS_EN
    // A read may pass the buffer only if no live entry targets the same word.
    logic [AW-1:0]    offs [DEPTH];
    logic [DEPTH-1:0] hit;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            offs[i] = AW'(i) - headIdx;
            hit[i]  = ({1'b0, offs[i]} < count_q) &&
                      (entAddr_q[i][31:2] == data_addr[31:2]);
        end
    end
    assign orderOk = ~|hit;
`else
    assign orderOk = wbuf_empty;
`endif

    assign rdAllowed    = (state_q == IDLE) && !rdOut_q && orderOk;
    assign data_addr_ok = !reset && (data_wr ? (count_q < FULL_CNT) : rdAllowed);
    assign push         = data_req && data_wr && data_addr_ok;
    assign rdAccept     = data_req && !data_wr && data_addr_ok;
    assign pop          = (state_q == WR_WAIT) && mem_data_ok;

    assign data_data_ok = !reset && (wrAck_q || ((state_q == RD_WAIT) && mem_data_ok));
    assign data_rdata   = mem_rdata;

    assign rdSel     = (state_q == RD_ADDR);
    assign mem_req   = memReq_q && !reset;
    assign mem_wr    = !rdSel;
    assign mem_addr  = rdSel ? rdAddr_q  : entAddr_q[headIdx];
    assign mem_size  = rdSel ? rdSize_q  : entSize_q[headIdx];
    assign mem_cache = rdSel ? rdCache_q : entCache_q[headIdx];
    assign mem_wstrb = rdSel ? 4'h0      : entStrb_q[headIdx];
    assign mem_wdata = rdSel ? 32'h0     : entData_q[headIdx];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) wrPtr_d = wrPtr_q + 1'b1;
        if (pop)  rdPtr_d = rdPtr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            wrAck_q <= 1'b0;
            rdOut_q <= 1'b0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            wrAck_q <= push;
            if (rdAccept)
                rdOut_q <= 1'b1;
            else if ((state_q == RD_WAIT) && mem_data_ok)
                rdOut_q <= 1'b0;
        end
    end

    // Payload storage carries no reset; liveness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            entAddr_q[tailIdx]  <= data_addr;
            entData_q[tailIdx]  <= data_wdata;
            entStrb_q[tailIdx]  <= data_wstrb;
            entSize_q[tailIdx]  <= data_size;
            entCache_q[tailIdx] <= data_cache;
        end
        if (rdAccept) begin
            rdAddr_q  <= data_addr;
            rdSize_q  <= data_size;
            rdCache_q <= data_cache;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            memReq_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rdAccept) begin
                        state_q  <= RD_ADDR;
                        memReq_q <= 1'b1;
                    end else if (count_q != '0) begin
                        state_q  <= WR_ADDR;
                        memReq_q <= 1'b1;
                    end
                end
                WR_ADDR: if (mem_addr_ok) begin
                    state_q  <= WR_WAIT;
                    memReq_q <= 1'b0;
                end
                WR_WAIT: if (mem_data_ok) state_q <= IDLE;
                RD_ADDR: if (mem_addr_ok) begin
                    state_q  <= RD_WAIT;
                    memReq_q <= 1'b0;
                end
                RD_WAIT: if (mem_data_ok) state_q <= IDLE;
                default: begin
                    state_q  <= IDLE;
                    memReq_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_wbuf.sv
// Directed bench for data_wbuf: a vector table plus hand-written multi-cycle sequences.
// Expectations for read bypass follow the WBUF_READ_BYPASS_EN build macro.
`timescale 1ns/1ps
module tb_data_wbuf;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_req = 1'b0, data_cache = 1'b0, data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic [2:0]  data_size = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_cache, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wbuf_empty;

    int vecCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    data_wbuf #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_cache(mem_cache), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .wbuf_empty(wbuf_empty)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  size;
        logic        cache;
        logic [31:0] memRdata;
        logic [31:0] expMemAddr;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic [2:0] size, input logic cache);
        data_req   = req;
        data_wr    = wr;
        data_addr  = addr;
        data_wdata = wdata;
        data_wstrb = strb;
        data_size  = size;
        data_cache = cache;
    endtask

    task automatic coreWrite(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] size, input logic cache);
        waitCycle();
        applyStimulus(1'b1, 1'b1, addr, wdata, strb, size, cache);
        #1 checkOutput("wr_addr_ok", 32'(data_addr_ok), 32'd1);
        waitCycle();
        data_req = 1'b0;
        #1 checkOutput("wr_data_ok", 32'(data_data_ok), 32'd1);
    endtask

    task automatic coreRead(input logic [31:0] addr, input logic [2:0] size, input logic cache);
        waitCycle();
        applyStimulus(1'b1, 1'b0, addr, 32'h0, 4'h0, size, cache);
        #1 checkOutput("rd_addr_ok", 32'(data_addr_ok), 32'd1);
        waitCycle();
        data_req = 1'b0;
    endtask

    // Waits for a memory request, checks it, then completes it with one addr_ok and one data_ok.
    task automatic memServe(input string tag, input logic [31:0] eAddr, input logic eWr,
                            input logic [31:0] eData, input logic [3:0] eStrb,
                            input logic [2:0] eSize, input logic eCache, input logic [31:0] rdata);
        int n = 0;
        waitCycle();
        #1;
        while (!mem_req && n < 20) begin
            waitCycle();
            #1;
            n++;
        end
        checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        if (!mem_req) return;
        checkOutput({tag, "_mem_addr"}, mem_addr, eAddr);
        checkOutput({tag, "_mem_wr"}, 32'(mem_wr), 32'(eWr));
        checkOutput({tag, "_mem_size"}, 32'(mem_size), 32'(eSize));
        checkOutput({tag, "_mem_cache"}, 32'(mem_cache), 32'(eCache));
        if (eWr) begin
            checkOutput({tag, "_mem_wdata"}, mem_wdata, eData);
            checkOutput({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(eStrb));
        end
        mem_addr_ok = 1'b1;
        waitCycle();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rdata;
        #1 checkOutput({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        if (!eWr) begin
            checkOutput({tag, "_rd_data_ok"}, 32'(data_data_ok), 32'd1);
            checkOutput({tag, "_rd_rdata"}, data_rdata, rdata);
        end
        waitCycle();
        mem_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'hBFAF_F000, 32'h1234_5678, 4'hF, 3'd2, 1'b1, 32'h0, 32'hBFAF_F000, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3, 3'd1, 1'b0, 32'h0, 32'h0000_1004, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, 3'd2, 1'b0, 32'hCAFE_F00D, 32'h0000_1004, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'h1FC0_0008, 32'hA5A5_0000, 4'hC, 3'd1, 1'b1, 32'h0, 32'h1FC0_0008, 32'h0};
        vecs[4] = '{1'b0, 32'hBFAF_F000, 32'h0, 4'h0, 3'd2, 1'b1, 32'h8765_4321, 32'hBFAF_F000, 32'h8765_4321};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h1, 3'd0, 1'b0, 32'h0, 32'h0000_0000, 32'h0};

        // Reset: outputs held quiet even with a write request presented.
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h1, 4'hF, 3'd2, 1'b1);
        waitCycle();
        waitCycle();
        #1;
        checkOutput("rst_addr_ok", 32'(data_addr_ok), 32'd0);
        checkOutput("rst_data_ok", 32'(data_data_ok), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_empty", 32'(wbuf_empty), 32'd1);
        reset = 1'b0;
        data_req = 1'b0;
        waitCycle();
        #1;
        checkOutput("post_rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("post_rst_empty", 32'(wbuf_empty), 32'd1);

        // Table of single transactions, each fully drained.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr) begin
                coreWrite(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].size, vecs[i].cache);
                checkOutput("vec_busy", 32'(wbuf_empty), 32'd0);
                memServe("vec_wr", vecs[i].expMemAddr, 1'b1, vecs[i].wdata, vecs[i].strb,
                         vecs[i].size, vecs[i].cache, 32'h0);
            end else begin
                coreRead(vecs[i].addr, vecs[i].size, vecs[i].cache);
                memServe("vec_rd", vecs[i].expMemAddr, 1'b0, 32'h0, 4'h0,
                         vecs[i].size, vecs[i].cache, vecs[i].memRdata);
                checkOutput("vec_rd_rdata", data_rdata, vecs[i].expRdata);
            end
            #1 checkOutput("vec_empty", 32'(wbuf_empty), 32'd1);
        end

        // Full: four writes fill the buffer, the fifth waits until a slot frees.
        for (int i = 0; i < 4; i++) begin
            waitCycle();
            applyStimulus(1'b1, 1'b1, 32'h500 + 32'(4 * i), 32'hF000 + 32'(i), 4'hF, 3'd2, 1'b1);
            #1 checkOutput("full_accept", 32'(data_addr_ok), 32'd1);
            if (i > 0) checkOutput("full_ack", 32'(data_data_ok), 32'd1);
        end
        waitCycle();
        applyStimulus(1'b1, 1'b1, 32'h510, 32'hF004, 4'hF, 3'd2, 1'b1);
        #1;
        checkOutput("full_ack4", 32'(data_data_ok), 32'd1);
        checkOutput("full_stall", 32'(data_addr_ok), 32'd0);
        checkOutput("full_head_addr", mem_addr, 32'h500);
        waitCycle();
        #1 checkOutput("full_stall2", 32'(data_addr_ok), 32'd0);
        mem_addr_ok = 1'b1;
        waitCycle();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1 checkOutput("full_retire_stall", 32'(data_addr_ok), 32'd0);
        waitCycle();
        mem_data_ok = 1'b0;
        #1 checkOutput("full_reopen", 32'(data_addr_ok), 32'd1);
        waitCycle();
        data_req = 1'b0;
        #1 checkOutput("full_ack5", 32'(data_data_ok), 32'd1);
        for (int i = 1; i < 5; i++)
            memServe("full_drain", 32'h500 + 32'(4 * i), 1'b1, 32'hF000 + 32'(i), 4'hF, 3'd2, 1'b1, 32'h0);

        // Ordering with pointer wrap: ten writes in pairs.
        for (int b = 0; b < 5; b++) begin
            coreWrite(32'h100 + 32'(8 * b), 32'hA000 + 32'(b), 4'hF, 3'd2, 1'b0);
            coreWrite(32'h104 + 32'(8 * b), 32'hB000 + 32'(b), 4'hF, 3'd2, 1'b0);
            memServe("ord", 32'h100 + 32'(8 * b), 1'b1, 32'hA000 + 32'(b), 4'hF, 3'd2, 1'b0, 32'h0);
            memServe("ord", 32'h104 + 32'(8 * b), 1'b1, 32'hB000 + 32'(b), 4'hF, 3'd2, 1'b0, 32'h0);
        end

        // Read after write to the same word waits for the write to retire.
        waitCycle();
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h2222_0000, 4'hF, 3'd2, 1'b1);
        #1 checkOutput("raw_wr_accept", 32'(data_addr_ok), 32'd1);
        waitCycle();
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 3'd2, 1'b1);
        #1;
        checkOutput("raw_wr_ack", 32'(data_data_ok), 32'd1);
        checkOutput("raw_rd_stall", 32'(data_addr_ok), 32'd0);
        memServe("raw_wr", 32'h200, 1'b1, 32'h2222_0000, 4'hF, 3'd2, 1'b1, 32'h0);
        #1 checkOutput("raw_rd_accept", 32'(data_addr_ok), 32'd1);
        waitCycle();
        data_req = 1'b0;
        memServe("raw_rd", 32'h200, 1'b0, 32'h0, 4'h0, 3'd2, 1'b1, 32'h2222_0000);

        // Read to a different word while a write is buffered.
        waitCycle();
        applyStimulus(1'b1, 1'b1, 32'h300, 32'h3333_0000, 4'hF, 3'd2, 1'b1);
        #1 checkOutput("byp_wr_accept", 32'(data_addr_ok), 32'd1);
        waitCycle();
        applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 3'd2, 1'b0);
        #1 checkOutput("byp_wr_ack", 32'(data_data_ok), 32'd1);
`ifdef WBUF_READ_BYPASS_EN
        checkOutput("byp_rd_accept", 32'(data_addr_ok), 32'd1);
        waitCycle();
        data_req = 1'b0;
        memServe("byp_rd_first", 32'h400, 1'b0, 32'h0, 4'h0, 3'd2, 1'b0, 32'h4444_0000);
        memServe("byp_wr_second", 32'h300, 1'b1, 32'h3333_0000, 4'hF, 3'd2, 1'b1, 32'h0);
`else
        checkOutput("byp_rd_stall", 32'(data_addr_ok), 32'd0);
        memServe("byp_wr_first", 32'h300, 1'b1, 32'h3333_0000, 4'hF, 3'd2, 1'b1, 32'h0);
        #1 checkOutput("byp_rd_accept", 32'(data_addr_ok), 32'd1);
        waitCycle();
        data_req = 1'b0;
        memServe("byp_rd_second", 32'h400, 1'b0, 32'h0, 4'h0, 3'd2, 1'b0, 32'h4444_0000);
`endif

        // Reset while a write is in WR_WAIT with three entries buffered.
        coreWrite(32'h600, 32'h6000, 4'hF, 3'd2, 1'b1);
        coreWrite(32'h604, 32'h6004, 4'hF, 3'd2, 1'b1);
        coreWrite(32'h608, 32'h6008, 4'hF, 3'd2, 1'b1);
        for (int n = 0; n < 20 && !mem_req; n++) begin
            waitCycle();
            #1;
        end
        checkOutput("mid_mem_req", 32'(mem_req), 32'd1);
        mem_addr_ok = 1'b1;
        waitCycle();
        mem_addr_ok = 1'b0;
        waitCycle();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h700, 32'h7000, 4'hF, 3'd2, 1'b0);
        #1;
        checkOutput("mid_rst_addr_ok", 32'(data_addr_ok), 32'd0);
        checkOutput("mid_rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("mid_rst_empty", 32'(wbuf_empty), 32'd1);
        waitCycle();
        reset = 1'b0;
        data_req = 1'b0;
        #1;
        checkOutput("mid_after_mem_req", 32'(mem_req), 32'd0);
        checkOutput("mid_after_empty", 32'(wbuf_empty), 32'd1);
        mem_data_ok = 1'b1;
        #1 checkOutput("mid_stale_data_ok", 32'(data_data_ok), 32'd0);
        waitCycle();
        mem_data_ok = 1'b0;
        #1;
        checkOutput("mid_idle_mem_req", 32'(mem_req), 32'd0);
        checkOutput("mid_idle_empty", 32'(wbuf_empty), 32'd1);
        coreWrite(32'h700, 32'h7000, 4'hF, 3'd2, 1'b0);
        memServe("mid_fresh", 32'h700, 1'b1, 32'h7000, 4'hF, 3'd2, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
